// File: rtl/bullcow_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bullcow_pkg
// Description : Shared types, digit geometry and guess-validity helper for the
//               Bull-Cow front end and game core.
// Revision    : 1.0 - initial release
// ============================================================================
package bullcow_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } debounce_state_t;

  // A guess is valid only when no two of its hex digits repeat.
  function automatic logic digits_distinct_f(input logic [15:0] guess);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      for (int j = i + 1; j < NUM_DIGITS; j++) begin
        if (guess[i*DIGIT_W +: DIGIT_W] == guess[j*DIGIT_W +: DIGIT_W]) begin
          ok = 1'b0;
        end
      end
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : Multi-stage flop synchroniser for asynchronous inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_stage[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/bullcow_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : bullcow_input_conditioner
// Description : Synchronises board inputs, debounces the enter button and
//               emits a validated enter/reject strobe with a switch snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
module bullcow_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enter_raw,
  input  logic [15:0] SW_raw,
  output logic [15:0] SW_sync,
  output logic [15:0] SW_guess,
  output logic        digits_distinct,
  output logic        enter_held,
  output logic        enter_pulse,
  output logic        enter_reject
);

  import bullcow_pkg::*;

  localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 2);

  logic               w_enter_s;
  debounce_state_t    r_state;
  debounce_state_t    w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_accept;

  sync_ff #(
    .WIDTH       (1),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_enter_sync (
    .clock (clock),
    .reset (reset),
    .i_d   (enter_raw),
    .o_q   (w_enter_s)
  );

  sync_ff #(
    .WIDTH       (16),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sw_sync (
    .clock (clock),
    .reset (reset),
    .i_d   (SW_raw),
    .o_q   (SW_sync)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_enter_s) w_state_nxt = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!w_enter_s) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = HELD;
          w_accept    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      HELD: begin
        if (!w_enter_s) w_state_nxt = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (w_enter_s) begin
          w_state_nxt = HELD;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Every state entry starts a fresh stability count.
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      SW_guess        <= '0;
      digits_distinct <= 1'b0;
      enter_pulse     <= 1'b0;
      enter_reject    <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      digits_distinct <= digits_distinct_f(SW_sync);
      enter_pulse     <= w_accept & digits_distinct;
      enter_reject    <= w_accept & ~digits_distinct;
      if (w_accept) SW_guess <= SW_sync;
    end
  end

  assign enter_held = (r_state == HELD) || (r_state == RELEASE_WAIT);

endmodule
`default_nettype wire

// File: doc/bullcow_input_conditioner.md
Name: bullcow_input_conditioner

Overview:
Front-end stage directly upstream of the Bull-Cow game core. It takes the raw board inputs (enter button, 16 slide switches), synchronises them into the clock domain and debounces the button. It emits a single-cycle, validated enter event plus a latched switch snapshot for the game core to consume. Guesses whose four hex digits are not pairwise distinct produce a reject pulse instead of an enter pulse.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz); legal range >= 2.
SYNC_STAGES, 2, flip-flop depth of the input synchronisers; legal range >= 2.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset; 0 = reset asserted
enter_raw  in  1  raw push-button, active-high, asynchronous
SW_raw  in  16  raw slide switches, asynchronous; four hex digits, SW[15:12] = digit 3
SW_sync  out  16  synchronised switch value, continuously tracking
SW_guess  out  16  switch snapshot latched on each accepted press
digits_distinct  out  1  registered; 1 when the four nibbles of SW_sync are pairwise different
enter_held  out  1  1 while the debounced button is in the pressed state
enter_pulse  out  1  one-cycle strobe: press accepted with a distinct-digit guess
enter_reject  out  1  one-cycle strobe: press accepted but digits not distinct

Behaviour:
- Reset (reset == 0, asynchronous): all synchroniser flops, counter, FSM (IDLE) and every output go to 0. Release is synchronous to clock through the existing flops. No pulse may be generated by reset release itself.
- Synchronisers: enter_raw and SW_raw each pass through SYNC_STAGES flops. enter_s is the last stage. SW_sync equals the last stage, giving a latency of SYNC_STAGES cycles.
- digits_distinct: registered from SW_sync, so it lags SW_sync by 1 cycle. It checks all 6 nibble pairs.
- Debounce FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. The counter has width $clog2(DEBOUNCE_CYCLES) and clears on every state entry.
  - IDLE: enter_s = 1 -> PRESS_WAIT.
  - PRESS_WAIT: enter_s = 0 -> IDLE (glitch rejected, no pulse). If the counter equals DEBOUNCE_CYCLES-2 with enter_s = 1 -> HELD. Otherwise the counter increments.
  - HELD: enter_s = 0 -> RELEASE_WAIT.
  - RELEASE_WAIT: enter_s = 1 -> HELD (bounce on release; no new pulse). If the counter equals DEBOUNCE_CYCLES-2 with enter_s = 0 -> IDLE.
- Acceptance timing: the PRESS_WAIT -> HELD transition occurs after exactly DEBOUNCE_CYCLES consecutive cycles of enter_s = 1, counting the IDLE cycle that sees it.
- enter_held = 1 in HELD and RELEASE_WAIT.
- On the clock edge entering HELD from PRESS_WAIT:
  - SW_guess <= SW_sync.
  - enter_pulse <= digits_distinct and enter_reject <= ~digits_distinct, both for exactly one cycle.
  - enter_pulse and enter_reject are never high together.
- SW_guess holds its value until the next accepted press. Switch changes while the button is held do not alter SW_guess.
- Holding the button indefinitely yields exactly one strobe. A new strobe requires a full debounced release (return to IDLE) first.
- Mid-operation reset: the FSM and outputs clear immediately. A button still physically held after release re-enters via IDLE -> PRESS_WAIT and produces a fresh strobe after DEBOUNCE_CYCLES cycles. This is intended.

Decomposition:
- Package bullcow_pkg:
  - debounce_state_t enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT).
  - NUM_DIGITS = 4 and DIGIT_W = 4.
  - function digits_distinct_f(logic [15:0]), shared with the game core.
- Sub-module sync_ff, parameterised by width and SYNC_STAGES, instantiated twice: 1 bit for enter, 16 bits for switches.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4 and SYNC_STAGES = 2.
1. Reset: reset = 0 with enter_raw = 1 and SW_raw = 16'h1234 -> all outputs 0; after reset = 1, SW_sync = 16'h1234 two cycles later.
2. Clean press, SW_raw = 16'h1234: enter_raw held high -> enter_pulse high for exactly 1 cycle, 2 + 4 cycles after the rising edge; SW_guess = 16'h1234; enter_reject stays 0.
3. Duplicate digits, SW_raw = 16'h1123: clean press -> enter_reject 1 cycle, enter_pulse 0, SW_guess = 16'h1123.
4. Bounce: enter_raw toggles 1,0,1,0 every cycle, then holds high -> exactly one enter_pulse, occurring 4 cycles after enter_s last went high. Release bounce (0,1,0, then hold low) -> no extra pulse; enter_held falls only after 4 stable-low cycles.
5. Long hold of 50 cycles with SW changing 16'h1234 -> 16'h5678 mid-hold -> one pulse only; SW_guess stays 16'h1234; SW_sync follows to 16'h5678.
6. Asynchronous reset asserted during HELD -> outputs clear immediately without waiting for a clock edge. With the button still held after release, one new enter_pulse follows 2 + 4 cycles later.
